// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolution line feeder.
// Default widths and tap count used by conv_line_feeder and its weight store.
package conv_pkg;

   localparam int K      = 5;
   localparam int I_X    = 8;
   localparam int I_W    = 8;
   localparam int I_PSUM = 16;
   localparam int LEN_W  = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_W = 3'd1,
      FETCH  = 3'd2,
      EMIT   = 3'd3,
      DONE   = 3'd4
   } state_t;

   // Index width that stays legal for a single-entry table.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/conv_weight_regs.sv
// K x I_W weight register file: one indexed write port, one indexed read port,
// asynchronous active-low clear.
module conv_weight_regs
   import conv_pkg::*;
#(
   parameter int K     = conv_pkg::K,
   parameter int I_W   = conv_pkg::I_W,
   parameter int IDX_W = idx_width(conv_pkg::K)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [I_W-1:0]   wr_data,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [I_W-1:0]   rd_data
);

   logic [I_W-1:0] w_reg [K];

   genvar gi;
   generate
      for (gi = 0; gi < K; gi++) begin : g_w
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               w_reg[gi] <= '0;
            end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
               w_reg[gi] <= wr_data;
            end
         end
      end
   endgenerate

   // Out-of-range indices read as zero rather than aliasing an entry.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < K; i++) begin
         if (rd_idx == IDX_W'(i)) rd_data = w_reg[i];
      end
   end

endmodule

// File: rtl/conv_line_feeder.sv
// Sequencer feeding (pixel, weight, psum) beats to the 5-tap convolution line.
// Optional i_psum input enabled by defining CONV_FEEDER_PSUM_IN_EN.
module conv_line_feeder
   import conv_pkg::*;
#(
   parameter int I_X    = conv_pkg::I_X,
   parameter int I_W    = conv_pkg::I_W,
   parameter int I_PSUM = conv_pkg::I_PSUM,
   parameter int K      = conv_pkg::K,
   parameter int LEN_W  = conv_pkg::LEN_W
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic [LEN_W-1:0]     i_len,
   input  logic                 i_w_valid,
   input  logic [I_W-1:0]       i_w,
   output logic                 o_w_ready,
   input  logic                 i_x_valid,
   input  logic [I_X-1:0]       i_x,
   output logic                 o_x_ready,
`ifdef CONV_FEEDER_PSUM_IN_EN
   input  logic [I_PSUM-1:0]    i_psum,
`endif
   output logic                 o_valid,
   output logic [I_X-1:0]       o_x,
   output logic [I_W-1:0]       o_w,
   output logic [I_PSUM-1:0]    o_psum,
   output logic [$clog2(K)-1:0] o_tap,
   output logic                 o_last,
   input  logic                 i_ready,
   output logic                 o_busy,
   output logic                 o_done
);

   localparam int TW = $clog2(K);
   localparam logic [TW-1:0] TAP_LAST = TW'(K - 1);

   state_t state_reg, state_next;
   logic [TW-1:0]    wcnt_reg, wcnt_next;
   logic [TW-1:0]    tap_reg, tap_next;
   logic [LEN_W-1:0] rem_reg, rem_next;
   logic [I_X-1:0]   x_reg, x_next;
   logic [I_W-1:0]   w_rd;
   logic             w_hs, x_hs, out_hs;

   // Handshake readiness and beat validity follow the state register only.
   assign o_w_ready = (state_reg == LOAD_W);
   assign o_x_ready = (state_reg == FETCH);
   assign o_valid   = (state_reg == EMIT);
   assign o_busy    = (state_reg != IDLE);
   assign o_done    = (state_reg == DONE);

   assign w_hs   = o_w_ready & i_w_valid;
   assign x_hs   = o_x_ready & i_x_valid;
   assign out_hs = o_valid & i_ready;

   conv_weight_regs #(
      .K     (K),
      .I_W   (I_W),
      .IDX_W (TW)
   ) u_weight_regs (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .wr_en   (w_hs),
      .wr_idx  (wcnt_reg),
      .wr_data (i_w),
      .rd_idx  (tap_reg),
      .rd_data (w_rd)
   );

   always_comb begin
      state_next = state_reg;
      wcnt_next  = wcnt_reg;
      tap_next   = tap_reg;
      rem_next   = rem_reg;
      x_next     = x_reg;
      case (state_reg)
         IDLE: begin
            if (i_start) begin
               rem_next   = i_len;
               wcnt_next  = '0;
               state_next = (i_len == '0) ? DONE : LOAD_W;
            end
         end
         LOAD_W: begin
            if (w_hs) begin
               wcnt_next = wcnt_reg + 1'b1;
               if (wcnt_reg == TAP_LAST) state_next = FETCH;
            end
         end
         FETCH: begin
            if (x_hs) begin
               x_next     = i_x;
               tap_next   = '0;
               state_next = EMIT;
            end
         end
         EMIT: begin
            if (out_hs) begin
               if (tap_reg != TAP_LAST) begin
                  tap_next = tap_reg + 1'b1;
               end else if (rem_reg > LEN_W'(1)) begin
                  rem_next   = rem_reg - 1'b1;
                  state_next = FETCH;
               end else begin
                  state_next = DONE;
               end
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg <= IDLE;
         wcnt_reg  <= '0;
         tap_reg   <= '0;
         rem_reg   <= '0;
         x_reg     <= '0;
      end else begin
         state_reg <= state_next;
         wcnt_reg  <= wcnt_next;
         tap_reg   <= tap_next;
         rem_reg   <= rem_next;
         x_reg     <= x_next;
      end
   end

`ifdef CONV_FEEDER_PSUM_IN_EN
   logic [I_PSUM-1:0] psum_reg, psum_next;

   // The incoming partial sum travels with its pixel across all K beats.
   always_comb begin
      psum_next = psum_reg;
      if (x_hs) psum_next = i_psum;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) psum_reg <= '0;
      else          psum_reg <= psum_next;
   end

   assign o_psum = psum_reg;
`else
   assign o_psum = '0;
`endif

   assign o_x    = x_reg;
   assign o_w    = w_rd;
   assign o_tap  = tap_reg;
   assign o_last = o_valid && (tap_reg == TAP_LAST) && (rem_reg == LEN_W'(1));

endmodule

// File: doc/conv_line_feeder.md
Name: conv_line_feeder

Overview:
- Transmit-side sequencer driving the i_x / i_w / i_psum inputs of the 5-tap convolution line.
- Loads K kernel weights, then streams one row of pixels, emitting K (pixel, weight) beats per pixel.
- Each beat uses a valid/ready handshake so the line or a downstream FIFO can stall the feeder.
- Sits between the weight/pixel memory readers and the convolution line.

Parameters:
- I_X, 8, pixel width (signed)
- I_W, 8, weight width (signed)
- I_PSUM, 16, partial-sum width (signed)
- K, 5, taps per pixel and weights per load
- LEN_W, 8, width of the row-length field

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  row start pulse, honoured only in IDLE
- i_len  in  LEN_W  pixels in the row, sampled on accepted i_start
- i_w_valid  in  1  weight beat valid
- i_w  in  I_W  weight data
- o_w_ready  out  1  weight accept
- i_x_valid  in  1  pixel beat valid
- i_x  in  I_X  pixel data
- o_x_ready  out  1  pixel accept
- o_valid  out  1  beat valid to the line
- o_x  out  I_X  pixel for this beat
- o_w  out  I_W  weight for this beat
- o_psum  out  I_PSUM  incoming partial sum for this beat
- o_tap  out  $clog2(K)  tap index of this beat
- o_last  out  1  final beat of the row
- i_ready  in  1  downstream accept
- o_busy  out  1  high when not in IDLE
- o_done  out  1  one-cycle row-complete pulse

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE, and the following are all 0: every output, weight registers, counters, pixel/psum registers.
- Reset mid-operation aborts the row; no o_done is produced.
- Handshakes fire on the clock edge where valid&ready=1.
- o_w_ready and o_x_ready decode directly from state.
- o_valid, o_x, o_w, o_psum, o_tap and o_last are registered. They hold stable while o_valid=1 and i_ready=0.
- IDLE:
  - On i_start, latch i_len into rem.
  - If i_len=0, go to DONE; otherwise go to LOAD_W with wcnt=0.
- LOAD_W:
  - o_w_ready=1.
  - Each handshake writes wreg[wcnt] and increments wcnt.
  - The K-th handshake moves to FETCH.
  - Weights are reloaded on every row.
- FETCH:
  - o_x_ready=1.
  - Handshake latches the pixel into xreg, sets tap=0, and moves to EMIT.
- EMIT:
  - o_valid=1, o_x=xreg, o_w=wreg[tap], o_tap=tap, o_psum=0.
  - o_last=(tap==K-1)&&(rem==1).
  - On handshake with tap<K-1: tap increments.
  - On handshake with tap==K-1 and rem>1: rem decrements, go to FETCH.
  - On handshake with tap==K-1 and rem==1: go to DONE.
- DONE: o_done=1 for one cycle, then IDLE.
- Throughput: with i_ready held high, K+1 cycles per pixel (one FETCH bubble).
- i_start outside IDLE is ignored. i_w_valid and i_x_valid are ignored when their ready is low.
- No arithmetic on data; widths pass through unchanged. rem counts down from i_len (max 2^LEN_W−1) and never wraps.

Optional Feature:
- Macro: CONV_FEEDER_PSUM_IN_EN.
- Defined:
  - Adds input port i_psum [I_PSUM].
  - i_psum is latched together with the pixel on the FETCH handshake.
  - o_psum carries that value on all K beats of the pixel.
- Undefined: no i_psum port; o_psum is constant 0 (first-line operation).

Decomposition:
- Shared package conv_pkg holds:
  - K and the default widths I_X, I_W, I_PSUM, LEN_W
  - state encoding: IDLE, LOAD_W, FETCH, EMIT, DONE
- One sub-module, conv_weight_regs: K×I_W register file with write port (en, index, data), read port (index), async clear.

Test Plan:
- Reset: assert i_rst_n=0 mid-EMIT, then release → state IDLE; all outputs 0; o_done never pulses.
- Nominal row:
  - Stimulus: i_len=2, weights 1,−2,3,−4,5, pixels 10 then −3, i_ready=1.
  - Response: 10 beats (10,1)(10,−2)(10,3)(10,−4)(10,5)(−3,1)…(−3,5); o_tap 0..4 twice.
  - o_last only on beat 10; o_done one cycle after the beat-10 handshake.
- Backpressure: hold i_ready=0 for 3 cycles at tap 2 of pixel 10 → o_x=10, o_w=3, o_tap=2 stable for all 3 cycles; sequence resumes unchanged.
- Zero length: i_start with i_len=0 → o_done on the next cycle; o_w_ready, o_x_ready and o_valid never assert.
- Ignored start: pulse i_start during LOAD_W with a different i_len → the original row completes with the original length.
- CONV_FEEDER_PSUM_IN_EN defined: i_psum=100 with pixel 7, i_len=1 → all 5 beats show o_psum=100; with the macro undefined, o_psum=0 on every beat.
